// File: rtl/procyon_rename_pkg.sv
// Shared core types for the rename stage: the resolved operand record and the zero-register index.
package procyon_rename_pkg;

  localparam int DATA_WIDTH       = 32;
  localparam int ROB_IDX_WIDTH    = 5;
  localparam int REGMAP_IDX_WIDTH = 5;

  localparam logic [REGMAP_IDX_WIDTH-1:0] REG_ZERO = '0;

  // Sized from the core widths above; the stage parameters are expected to match them.
  typedef struct packed {
    logic [DATA_WIDTH-1:0]    data;
    logic [ROB_IDX_WIDTH-1:0] tag;
    logic                     rdy;
  } operand_t;

endpackage

// File: rtl/procyon_rename_src.sv
// Per-source operand resolve plus the held operand register that snoops the CDB.
// PROCYON_RENAME_ROB_BYPASS_EN adds a completed-ROB-entry check between RAT ready and CDB hit.
module procyon_rename_src
  import procyon_rename_pkg::*;
#(
  parameter int OPTN_DATA_WIDTH       = DATA_WIDTH,
  parameter int OPTN_ROB_IDX_WIDTH    = ROB_IDX_WIDTH,
  parameter int OPTN_REGMAP_IDX_WIDTH = REGMAP_IDX_WIDTH,
  parameter int OPTN_CDB_DEPTH        = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_load,
  input  logic                             i_hold,
  input  logic [OPTN_REGMAP_IDX_WIDTH-1:0] i_src_idx,
  input  logic [OPTN_DATA_WIDTH-1:0]       i_rat_data,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0]    i_rat_tag,
  input  logic                             i_rat_rdy,
`ifdef PROCYON_RENAME_ROB_BYPASS_EN
  input  logic                             i_rob_rdy,
  input  logic [OPTN_DATA_WIDTH-1:0]       i_rob_data,
`endif
  input  logic                             i_cdb_en   [OPTN_CDB_DEPTH],
  input  logic [OPTN_ROB_IDX_WIDTH-1:0]    i_cdb_tag  [OPTN_CDB_DEPTH],
  input  logic [OPTN_DATA_WIDTH-1:0]       i_cdb_data [OPTN_CDB_DEPTH],
  output logic [OPTN_DATA_WIDTH-1:0]       o_data,
  output logic [OPTN_ROB_IDX_WIDTH-1:0]    o_tag,
  output logic                             o_rdy
);

  operand_t operand_q;
  operand_t operand_d;
  operand_t resolved;

  logic                       lookup_hit;
  logic [OPTN_DATA_WIDTH-1:0] lookup_data;
  logic                       snoop_hit;
  logic [OPTN_DATA_WIDTH-1:0] snoop_data;

  // Scanned high to low so the lowest-numbered matching port wins.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    snoop_hit   = 1'b0;
    snoop_data  = '0;
    for (int i = OPTN_CDB_DEPTH - 1; i >= 0; i--) begin
      if (i_cdb_en[i] && (i_cdb_tag[i] == i_rat_tag)) begin
        lookup_hit  = 1'b1;
        lookup_data = i_cdb_data[i];
      end
      if (i_cdb_en[i] && (i_cdb_tag[i] == operand_q.tag)) begin
        snoop_hit  = 1'b1;
        snoop_data = i_cdb_data[i];
      end
    end
  end

  always_comb begin
    resolved = '0;
    if (i_src_idx == REG_ZERO) begin
      resolved.rdy = 1'b1;
    end else if (i_rat_rdy) begin
      resolved.data = i_rat_data;
      resolved.tag  = i_rat_tag;
      resolved.rdy  = 1'b1;
`ifdef PROCYON_RENAME_ROB_BYPASS_EN
    end else if (i_rob_rdy) begin
      resolved.data = i_rob_data;
      resolved.tag  = i_rat_tag;
      resolved.rdy  = 1'b1;
`endif
    end else if (lookup_hit) begin
      resolved.data = lookup_data;
      resolved.tag  = i_rat_tag;
      resolved.rdy  = 1'b1;
    end else begin
      resolved.tag  = i_rat_tag;
    end
  end

  always_comb begin
    operand_d = operand_q;
    if (i_load) begin
      operand_d = resolved;
    end else if (i_hold && !operand_q.rdy && snoop_hit) begin
      operand_d.data = snoop_data;
      operand_d.rdy  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) operand_q <= '0;
    else     operand_q <= operand_d;
  end

  assign o_data = operand_q.data;
  assign o_tag  = operand_q.tag;
  assign o_rdy  = operand_q.rdy;

endmodule

// File: rtl/procyon_rename_stage.sv
// Single-entry dispatch/rename stage: RAT lookup, rename drive, and operand packet handoff to the RS.
// PROCYON_RENAME_ROB_BYPASS_EN adds ROB lookup inputs so completed entries resolve at accept.
module procyon_rename_stage
  import procyon_rename_pkg::*;
#(
  parameter int OPTN_DATA_WIDTH       = DATA_WIDTH,
  parameter int OPTN_ROB_IDX_WIDTH    = ROB_IDX_WIDTH,
  parameter int OPTN_REGMAP_IDX_WIDTH = REGMAP_IDX_WIDTH,
  parameter int OPTN_CDB_DEPTH        = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_flush,
  input  logic                             i_dispatch_valid,
  output logic                             o_dispatch_ready,
  input  logic [OPTN_REGMAP_IDX_WIDTH-1:0] i_dispatch_rs1,
  input  logic [OPTN_REGMAP_IDX_WIDTH-1:0] i_dispatch_rs2,
  input  logic [OPTN_REGMAP_IDX_WIDTH-1:0] i_dispatch_rdest,
  input  logic                             i_dispatch_has_rdest,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0]    i_dispatch_rob_tag,
  output logic [OPTN_REGMAP_IDX_WIDTH-1:0] o_rat_lookup_rs1,
  output logic [OPTN_REGMAP_IDX_WIDTH-1:0] o_rat_lookup_rs2,
  input  logic [OPTN_DATA_WIDTH-1:0]       i_rat_lookup_data [2],
  input  logic [OPTN_ROB_IDX_WIDTH-1:0]    i_rat_lookup_tag  [2],
  input  logic                             i_rat_lookup_rdy  [2],
`ifdef PROCYON_RENAME_ROB_BYPASS_EN
  input  logic                             i_rob_lookup_rdy  [2],
  input  logic [OPTN_DATA_WIDTH-1:0]       i_rob_lookup_data [2],
`endif
  output logic                             o_rat_rename_en,
  output logic [OPTN_REGMAP_IDX_WIDTH-1:0] o_rat_rename_rdest,
  output logic [OPTN_ROB_IDX_WIDTH-1:0]    o_rat_rename_tag,
  input  logic                             i_cdb_en   [OPTN_CDB_DEPTH],
  input  logic [OPTN_ROB_IDX_WIDTH-1:0]    i_cdb_tag  [OPTN_CDB_DEPTH],
  input  logic [OPTN_DATA_WIDTH-1:0]       i_cdb_data [OPTN_CDB_DEPTH],
  output logic                             o_rs_valid,
  input  logic                             i_rs_ready,
  output logic [OPTN_DATA_WIDTH-1:0]       o_rs_src_data [2],
  output logic [OPTN_ROB_IDX_WIDTH-1:0]    o_rs_src_tag  [2],
  output logic                             o_rs_src_rdy  [2],
  output logic [OPTN_ROB_IDX_WIDTH-1:0]    o_rs_rob_tag
);

  logic                             valid_q;
  logic                             valid_d;
  logic [OPTN_ROB_IDX_WIDTH-1:0]    rob_tag_q;
  logic [OPTN_ROB_IDX_WIDTH-1:0]    rob_tag_d;
  logic                             accept;
  logic [OPTN_REGMAP_IDX_WIDTH-1:0] src_idx [2];

  assign src_idx[0] = i_dispatch_rs1;
  assign src_idx[1] = i_dispatch_rs2;

  // Flush blocks acceptance outright, which also suppresses the rename strobe.
  always_comb begin
    o_dispatch_ready = !i_flush && (!valid_q || i_rs_ready);
    accept           = i_dispatch_valid && o_dispatch_ready;
    valid_d          = valid_q;
    rob_tag_d        = rob_tag_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d   = 1'b1;
      rob_tag_d = i_dispatch_rob_tag;
    end else if (valid_q && i_rs_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      rob_tag_q <= '0;
    end else begin
      valid_q   <= valid_d;
      rob_tag_q <= rob_tag_d;
    end
  end

  assign o_rat_lookup_rs1   = i_dispatch_rs1;
  assign o_rat_lookup_rs2   = i_dispatch_rs2;
  assign o_rat_rename_en    = accept && i_dispatch_has_rdest && (i_dispatch_rdest != REG_ZERO);
  assign o_rat_rename_rdest = i_dispatch_rdest;
  assign o_rat_rename_tag   = i_dispatch_rob_tag;
  assign o_rs_valid         = valid_q;
  assign o_rs_rob_tag       = rob_tag_q;

  for (genvar g = 0; g < 2; g++) begin : g_src
    procyon_rename_src #(
      .OPTN_DATA_WIDTH      (OPTN_DATA_WIDTH),
      .OPTN_ROB_IDX_WIDTH   (OPTN_ROB_IDX_WIDTH),
      .OPTN_REGMAP_IDX_WIDTH(OPTN_REGMAP_IDX_WIDTH),
      .OPTN_CDB_DEPTH       (OPTN_CDB_DEPTH)
    ) u_src (
      .clk       (clk),
      .rst       (rst),
      .i_load    (accept),
      .i_hold    (valid_q),
      .i_src_idx (src_idx[g]),
      .i_rat_data(i_rat_lookup_data[g]),
      .i_rat_tag (i_rat_lookup_tag[g]),
      .i_rat_rdy (i_rat_lookup_rdy[g]),
`ifdef PROCYON_RENAME_ROB_BYPASS_EN
      .i_rob_rdy (i_rob_lookup_rdy[g]),
      .i_rob_data(i_rob_lookup_data[g]),
`endif
      .i_cdb_en  (i_cdb_en),
      .i_cdb_tag (i_cdb_tag),
      .i_cdb_data(i_cdb_data),
      .o_data    (o_rs_src_data[g]),
      .o_tag     (o_rs_src_tag[g]),
      .o_rdy     (o_rs_src_rdy[g])
    );
  end

endmodule

// File: tb/tb_procyon_rename_stage.sv
// Bench for procyon_rename_stage: directed literal checks followed by randomized traffic
// against a behavioural packet model. Define PROCYON_RENAME_ROB_BYPASS_EN to exercise the ROB bypass.
module tb_procyon_rename_stage;

  localparam int DW  = 32;
  localparam int RW  = 5;
  localparam int GW  = 5;
  localparam int CDB = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_flush;
  logic          i_dispatch_valid;
  logic          o_dispatch_ready;
  logic [GW-1:0] i_dispatch_rs1, i_dispatch_rs2, i_dispatch_rdest;
  logic          i_dispatch_has_rdest;
  logic [RW-1:0] i_dispatch_rob_tag;
  logic [GW-1:0] o_rat_lookup_rs1, o_rat_lookup_rs2;
  logic [DW-1:0] i_rat_lookup_data [2];
  logic [RW-1:0] i_rat_lookup_tag  [2];
  logic          i_rat_lookup_rdy  [2];
`ifdef PROCYON_RENAME_ROB_BYPASS_EN
  logic          i_rob_lookup_rdy  [2];
  logic [DW-1:0] i_rob_lookup_data [2];
`endif
  logic          o_rat_rename_en;
  logic [GW-1:0] o_rat_rename_rdest;
  logic [RW-1:0] o_rat_rename_tag;
  logic          i_cdb_en   [CDB];
  logic [RW-1:0] i_cdb_tag  [CDB];
  logic [DW-1:0] i_cdb_data [CDB];
  logic          o_rs_valid;
  logic          i_rs_ready;
  logic [DW-1:0] o_rs_src_data [2];
  logic [RW-1:0] o_rs_src_tag  [2];
  logic          o_rs_src_rdy  [2];
  logic [RW-1:0] o_rs_rob_tag;

  int n_checks = 0;
  int n_errors = 0;

  logic          m_valid;
  logic [RW-1:0] m_rob;
  logic [DW-1:0] m_data [2];
  logic [RW-1:0] m_tag  [2];
  logic          m_rdy  [2];

  always #5 clk = ~clk;

  procyon_rename_stage dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_flush             (i_flush),
    .i_dispatch_valid    (i_dispatch_valid),
    .o_dispatch_ready    (o_dispatch_ready),
    .i_dispatch_rs1      (i_dispatch_rs1),
    .i_dispatch_rs2      (i_dispatch_rs2),
    .i_dispatch_rdest    (i_dispatch_rdest),
    .i_dispatch_has_rdest(i_dispatch_has_rdest),
    .i_dispatch_rob_tag  (i_dispatch_rob_tag),
    .o_rat_lookup_rs1    (o_rat_lookup_rs1),
    .o_rat_lookup_rs2    (o_rat_lookup_rs2),
    .i_rat_lookup_data   (i_rat_lookup_data),
    .i_rat_lookup_tag    (i_rat_lookup_tag),
    .i_rat_lookup_rdy    (i_rat_lookup_rdy),
`ifdef PROCYON_RENAME_ROB_BYPASS_EN
    .i_rob_lookup_rdy    (i_rob_lookup_rdy),
    .i_rob_lookup_data   (i_rob_lookup_data),
`endif
    .o_rat_rename_en     (o_rat_rename_en),
    .o_rat_rename_rdest  (o_rat_rename_rdest),
    .o_rat_rename_tag    (o_rat_rename_tag),
    .i_cdb_en            (i_cdb_en),
    .i_cdb_tag           (i_cdb_tag),
    .i_cdb_data          (i_cdb_data),
    .o_rs_valid          (o_rs_valid),
    .i_rs_ready          (i_rs_ready),
    .o_rs_src_data       (o_rs_src_data),
    .o_rs_src_tag        (o_rs_src_tag),
    .o_rs_src_rdy        (o_rs_src_rdy),
    .o_rs_rob_tag        (o_rs_rob_tag)
  );

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_idle();
    i_flush              = 1'b0;
    i_dispatch_valid     = 1'b0;
    i_dispatch_rs1       = '0;
    i_dispatch_rs2       = '0;
    i_dispatch_rdest     = '0;
    i_dispatch_has_rdest = 1'b0;
    i_dispatch_rob_tag   = '0;
    i_rs_ready           = 1'b1;
    for (int s = 0; s < 2; s++) begin
      i_rat_lookup_data[s] = '0;
      i_rat_lookup_tag[s]  = '0;
      i_rat_lookup_rdy[s]  = 1'b0;
`ifdef PROCYON_RENAME_ROB_BYPASS_EN
      i_rob_lookup_rdy[s]  = 1'b0;
      i_rob_lookup_data[s] = '0;
`endif
    end
    for (int p = 0; p < CDB; p++) begin
      i_cdb_en[p]   = 1'b0;
      i_cdb_tag[p]  = '0;
      i_cdb_data[p] = '0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    apply_idle();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_valid = 1'b0;
    m_rob   = '0;
    for (int s = 0; s < 2; s++) begin
      m_data[s] = '0;
      m_tag[s]  = '0;
      m_rdy[s]  = 1'b0;
    end
  endtask

  task automatic apply_dispatch(input logic [GW-1:0] rs1, input logic [GW-1:0] rs2,
                                input logic [GW-1:0] rdest, input logic has_rdest,
                                input logic [RW-1:0] rob_tag);
    i_dispatch_valid     = 1'b1;
    i_dispatch_rs1       = rs1;
    i_dispatch_rs2       = rs2;
    i_dispatch_rdest     = rdest;
    i_dispatch_has_rdest = has_rdest;
    i_dispatch_rob_tag   = rob_tag;
  endtask

  // Operand resolution from the current lookup/CDB inputs, by the priority list.
  function automatic void model_resolve(input int s, output logic [DW-1:0] d,
                                        output logic [RW-1:0] t, output logic r);
    logic [GW-1:0] idx;
    idx = (s == 0) ? i_dispatch_rs1 : i_dispatch_rs2;
    d = '0;
    t = '0;
    r = 1'b0;
    if (idx == 0) begin
      r = 1'b1;
      return;
    end
    t = i_rat_lookup_tag[s];
    if (i_rat_lookup_rdy[s]) begin
      d = i_rat_lookup_data[s];
      r = 1'b1;
      return;
    end
`ifdef PROCYON_RENAME_ROB_BYPASS_EN
    if (i_rob_lookup_rdy[s]) begin
      d = i_rob_lookup_data[s];
      r = 1'b1;
      return;
    end
`endif
    for (int p = 0; p < CDB; p++) begin
      if (i_cdb_en[p] && i_cdb_tag[p] == t) begin
        d = i_cdb_data[p];
        r = 1'b1;
        return;
      end
    end
  endfunction

  task automatic check_model_registered();
    check_output("rs_valid", {63'd0, o_rs_valid}, {63'd0, m_valid});
    if (m_valid) begin
      check_output("rs_rob_tag", 64'(o_rs_rob_tag), 64'(m_rob));
      for (int s = 0; s < 2; s++) begin
        check_output($sformatf("src%0d_rdy", s), {63'd0, o_rs_src_rdy[s]}, {63'd0, m_rdy[s]});
        if (m_rdy[s])
          check_output($sformatf("src%0d_data", s), 64'(o_rs_src_data[s]), 64'(m_data[s]));
        else
          check_output($sformatf("src%0d_tag", s), 64'(o_rs_src_tag[s]), 64'(m_tag[s]));
      end
    end
  endtask

  task automatic randomize_inputs();
    rst                  = ($urandom_range(0, 199) == 0);
    i_flush              = ($urandom_range(0, 15) == 0);
    i_dispatch_valid     = ($urandom_range(0, 3) != 0);
    i_rs_ready           = ($urandom_range(0, 3) != 0);
    i_dispatch_rs1       = GW'($urandom_range(0, 7));
    i_dispatch_rs2       = GW'($urandom_range(0, 7));
    i_dispatch_rdest     = GW'($urandom_range(0, 7));
    i_dispatch_has_rdest = 1'($urandom_range(0, 1));
    i_dispatch_rob_tag   = RW'($urandom);
    for (int s = 0; s < 2; s++) begin
      i_rat_lookup_data[s] = $urandom;
      i_rat_lookup_tag[s]  = RW'($urandom_range(0, 7));
      i_rat_lookup_rdy[s]  = 1'($urandom_range(0, 1));
`ifdef PROCYON_RENAME_ROB_BYPASS_EN
      i_rob_lookup_rdy[s]  = ($urandom_range(0, 3) == 0);
      i_rob_lookup_data[s] = $urandom;
`endif
    end
    for (int p = 0; p < CDB; p++) begin
      i_cdb_en[p]   = ($urandom_range(0, 2) == 0);
      i_cdb_tag[p]  = RW'($urandom_range(0, 7));
      i_cdb_data[p] = $urandom;
    end
    if (i_cdb_en[0] && i_cdb_en[1] && i_cdb_tag[0] == i_cdb_tag[1])
      i_cdb_tag[1] = i_cdb_tag[0] + RW'(1);
  endtask

  task automatic step_model();
    logic exp_ready, exp_accept, exp_ren;
    exp_ready  = !i_flush && (!m_valid || i_rs_ready);
    exp_accept = i_dispatch_valid && exp_ready;
    exp_ren    = exp_accept && i_dispatch_has_rdest && (i_dispatch_rdest != 0);
    check_output("dispatch_ready", {63'd0, o_dispatch_ready}, {63'd0, exp_ready});
    check_output("rename_en", {63'd0, o_rat_rename_en}, {63'd0, exp_ren});
    check_output("lookup_rs1", 64'(o_rat_lookup_rs1), 64'(i_dispatch_rs1));
    check_output("lookup_rs2", 64'(o_rat_lookup_rs2), 64'(i_dispatch_rs2));
    if (exp_ren) begin
      check_output("rename_rdest", 64'(o_rat_rename_rdest), 64'(i_dispatch_rdest));
      check_output("rename_tag", 64'(o_rat_rename_tag), 64'(i_dispatch_rob_tag));
    end
    if (rst) begin
      m_valid = 1'b0;
      m_rob   = '0;
      for (int s = 0; s < 2; s++) begin
        m_data[s] = '0;
        m_tag[s]  = '0;
        m_rdy[s]  = 1'b0;
      end
    end else if (i_flush) begin
      m_valid = 1'b0;
    end else if (exp_accept) begin
      m_valid = 1'b1;
      m_rob   = i_dispatch_rob_tag;
      for (int s = 0; s < 2; s++) model_resolve(s, m_data[s], m_tag[s], m_rdy[s]);
    end else if (m_valid) begin
      for (int s = 0; s < 2; s++) begin
        if (!m_rdy[s]) begin
          for (int p = 0; p < CDB; p++) begin
            if (!m_rdy[s] && i_cdb_en[p] && i_cdb_tag[p] == m_tag[s]) begin
              m_data[s] = i_cdb_data[p];
              m_rdy[s]  = 1'b1;
            end
          end
        end
      end
      if (i_rs_ready) m_valid = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    apply_idle();
    apply_reset();

    check_output("reset_rs_valid", {63'd0, o_rs_valid}, 64'd0);
    check_output("reset_rename_en", {63'd0, o_rat_rename_en}, 64'd0);
    check_output("reset_src0_rdy", {63'd0, o_rs_src_rdy[0]}, 64'd0);
    check_output("reset_src1_rdy", {63'd0, o_rs_src_rdy[1]}, 64'd0);
    check_output("reset_src0_data", 64'(o_rs_src_data[0]), 64'd0);
    check_output("reset_src1_tag", 64'(o_rs_src_tag[1]), 64'd0);
    check_output("reset_rob_tag", 64'(o_rs_rob_tag), 64'd0);

    apply_dispatch(5'd3, 5'd0, 5'd0, 1'b0, 5'd1);
    i_rat_lookup_rdy[0]  = 1'b1;
    i_rat_lookup_data[0] = 32'h11;
    @(negedge clk);
    check_output("t1_rs_valid", {63'd0, o_rs_valid}, 64'd1);
    check_output("t1_src0_data", 64'(o_rs_src_data[0]), 64'h11);
    check_output("t1_src1_data", 64'(o_rs_src_data[1]), 64'h0);
    check_output("t1_src0_rdy", {63'd0, o_rs_src_rdy[0]}, 64'd1);
    check_output("t1_src1_rdy", {63'd0, o_rs_src_rdy[1]}, 64'd1);

    apply_dispatch(5'd3, 5'd0, 5'd5, 1'b1, 5'd7);
    #1;
    check_output("t2_rename_en", {63'd0, o_rat_rename_en}, 64'd1);
    check_output("t2_rename_rdest", 64'(o_rat_rename_rdest), 64'd5);
    check_output("t2_rename_tag", 64'(o_rat_rename_tag), 64'd7);
    @(negedge clk);
    apply_dispatch(5'd5, 5'd0, 5'd0, 1'b0, 5'd8);
    i_rat_lookup_rdy[0] = 1'b0;
    i_rat_lookup_tag[0] = 5'd7;
    #1;
    check_output("t2_rename_once", {63'd0, o_rat_rename_en}, 64'd0);
    @(negedge clk);
    check_output("t2_src0_tag", 64'(o_rs_src_tag[0]), 64'd7);
    check_output("t2_src0_rdy", {63'd0, o_rs_src_rdy[0]}, 64'd0);
    check_output("t2_rob_tag", 64'(o_rs_rob_tag), 64'd8);

    apply_dispatch(5'd6, 5'd0, 5'd0, 1'b0, 5'd9);
    i_rat_lookup_tag[0] = 5'd4;
    @(negedge clk);
    i_rs_ready    = 1'b0;
    apply_dispatch(5'd2, 5'd0, 5'd0, 1'b0, 5'd12);
    i_cdb_en[0]   = 1'b1;
    i_cdb_tag[0]  = 5'd4;
    i_cdb_data[0] = 32'hAB;
    #1;
    check_output("t3_stall_ready", {63'd0, o_dispatch_ready}, 64'd0);
    @(negedge clk);
    i_cdb_en[0] = 1'b0;
    #1;
    check_output("t3_src0_rdy", {63'd0, o_rs_src_rdy[0]}, 64'd1);
    check_output("t3_src0_data", 64'(o_rs_src_data[0]), 64'hAB);
    check_output("t3_dispatch_ready", {63'd0, o_dispatch_ready}, 64'd0);
    check_output("t3_rob_tag_held", 64'(o_rs_rob_tag), 64'd9);

    i_rs_ready = 1'b1;
    apply_dispatch(5'd0, 5'd0, 5'd0, 1'b1, 5'd10);
    #1;
    check_output("t4_rdest0_rename", {63'd0, o_rat_rename_en}, 64'd0);
    check_output("t4_ready", {63'd0, o_dispatch_ready}, 64'd1);
    @(negedge clk);
    i_flush = 1'b1;
    apply_dispatch(5'd1, 5'd2, 5'd9, 1'b1, 5'd11);
    #1;
    check_output("t5_flush_rename", {63'd0, o_rat_rename_en}, 64'd0);
    check_output("t5_flush_ready", {63'd0, o_dispatch_ready}, 64'd0);
    @(negedge clk);
    apply_idle();
    check_output("t5_flush_valid", {63'd0, o_rs_valid}, 64'd0);

`ifdef PROCYON_RENAME_ROB_BYPASS_EN
    apply_dispatch(5'd4, 5'd0, 5'd0, 1'b0, 5'd13);
    i_rat_lookup_tag[0]  = 5'd9;
    i_rob_lookup_rdy[0]  = 1'b1;
    i_rob_lookup_data[0] = 32'h42;
    @(negedge clk);
    apply_idle();
    check_output("t6_rob_rdy", {63'd0, o_rs_src_rdy[0]}, 64'd1);
    check_output("t6_rob_data", 64'(o_rs_src_data[0]), 64'h42);
`endif

    apply_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      check_model_registered();
      randomize_inputs();
      #1;
      step_model();
    end

    @(negedge clk);
    apply_idle();
    rst = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
